// File: rtl/enc_2nrm_pkg.sv
// Shared definitions for the 2NRM encoder arbiter slice.
//   - Moduli of the residue number system used by encoder_2nrm.
//   - Bit positions of each residue inside the packed 64-bit word.
//   - Arbiter FSM state encoding and the packed residue word type.
package enc_2nrm_pkg;

    localparam int MOD_257 = 257;
    localparam int MOD_256 = 256;
    localparam int MOD_61  = 61;
    localparam int MOD_59  = 59;
    localparam int MOD_55  = 55;
    localparam int MOD_53  = 53;

    // Packed residue word layout; [63:55] and [13:0] are always zero.
    localparam int R257_MSB = 54;
    localparam int R257_LSB = 46;
    localparam int R256_MSB = 45;
    localparam int R256_LSB = 38;
    localparam int R61_MSB  = 37;
    localparam int R61_LSB  = 32;
    localparam int R59_MSB  = 31;
    localparam int R59_LSB  = 26;
    localparam int R55_MSB  = 25;
    localparam int R55_LSB  = 20;
    localparam int R53_MSB  = 19;
    localparam int R53_LSB  = 14;

    // Timeout counter width; TIMEOUT is limited to 1..15.
    localparam int TO_CNT_W = 4;

    typedef logic [63:0] residues_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/enc_2nrm_arbiter_rr_arbiter.sv
// Combinational round-robin search.
//   req_i   : request vector
//   ptr_i   : index where the search starts (wraps upward)
//   en_i    : when low no grant is produced
//   gnt_o   : one-hot grant
//   idx_o   : encoded index of the grant (0 when none)
//   valid_o : a grant was produced
// The pointer register is owned by the parent.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic                 en_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int W = $clog2(N);

    int unsigned cand;

    // NOTE: every output gets a default before the search so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (en_i && !valid_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = W'(cand);
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enc_2nrm_arbiter.sv
// Round-robin scheduler sharing one encoder_2nrm among N_REQ requesters.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid_i/_data : per-requester 16-bit word offers (word i at [16i+15:16i])
//   req_ready_o       : one-hot accept, only while idle
//   enc_start_o       : one-cycle start pulse to the encoder
//   enc_data_in_o     : latched word, stable from ISSUE through WAIT
//   enc_residues_i    : packed residues from the encoder
//   enc_done_i        : encoder completion pulse (only honoured in WAIT)
//   rsp_*             : response port (valid/ready) with requester id and error
//   busy_o            : FSM not idle
module enc_2nrm_arbiter
    import enc_2nrm_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [16*N_REQ-1:0]      req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     enc_start_o,
    output logic [15:0]              enc_data_in_o,
    input  logic [63:0]              enc_residues_i,
    input  logic                     enc_done_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic [63:0]              rsp_residues_o,
    output logic                     rsp_err_o,
    output logic                     busy_o
);

    localparam int ID_W = $clog2(N_REQ);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [15:0]         data_q, data_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    residues_t           res_q, res_d;
    logic                err_q, err_d;

    logic [N_REQ-1:0]    gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_valid;
    logic                arb_en;

    // rst_n is folded into the enable so req_ready stays low while reset is
    // held, even though the state register already reads IDLE.
    assign arb_en = (state_q == ST_IDLE) && rst_n;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .en_i    (arb_en),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    id_d     = gnt_idx;
                    data_d   = req_data_i[16*gnt_idx +: 16];
                    rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done is checked first so it wins over a simultaneous expiry.
                if (enc_done_i) begin
                    res_d   = enc_residues_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_CNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o    = gnt;
    assign enc_start_o    = (state_q == ST_ISSUE);
    assign enc_data_in_o  = data_q;
    assign rsp_valid_o    = (state_q == ST_RESP);
    assign rsp_id_o       = id_q;
    assign rsp_residues_o = res_q;
    assign rsp_err_o      = err_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_enc_2nrm_arbiter.sv
// Scoreboard bench for enc_2nrm_arbiter with a behavioural encoder stub.
module tb_enc_2nrm_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [16*N-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          enc_start;
    logic [15:0]   enc_data_in;
    logic [63:0]   enc_residues;
    logic          enc_done;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [1:0]    rsp_id;
    logic [63:0]   rsp_residues;
    logic          rsp_err;
    logic          busy;

    logic          stub_en = 1'b1;
    logic          stray_done = 1'b0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] res;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];

    enc_2nrm_arbiter #(.N_REQ(N), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .enc_start_o    (enc_start),
        .enc_data_in_o  (enc_data_in),
        .enc_residues_i (enc_residues),
        .enc_done_i     (enc_done),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_id_o       (rsp_id),
        .rsp_residues_o (rsp_residues),
        .rsp_err_o      (rsp_err),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pack(input int a, input int b, input int c,
                                         input int d, input int e, input int f);
        logic [63:0] w;
        w = '0;
        w[54:46] = 9'(a);
        w[45:38] = 8'(b);
        w[37:32] = 6'(c);
        w[31:26] = 6'(d);
        w[25:20] = 6'(e);
        w[19:14] = 6'(f);
        return w;
    endfunction

    function automatic logic [63:0] model_res(input logic [15:0] x);
        int v;
        v = int'(x);
        return pack(v % 257, v % 256, v % 61, v % 59, v % 55, v % 53);
    endfunction

    // Encoder stub: done one cycle after start; a stray done carries garbage.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_done     <= 1'b0;
            enc_residues <= '0;
        end else begin
            enc_done <= (stub_en && enc_start) || stray_done;
            if (enc_start) enc_residues <= model_res(enc_data_in);
            else if (stray_done) enc_residues <= 64'hDEAD_BEEF_0000_0000;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Drive point: 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic push_exp(input int id, input logic [63:0] res, input logic err);
        rsp_t e;
        e.id  = 2'(id);
        e.res = res;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(output int idx, output int at);
        idx = -1;
        at  = 0;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (req_ready != '0) begin
                idx = onehot_idx(req_ready);
                at  = cyc;
                break;
            end
            step();
        end
        if (idx < 0) check("grant_timeout", 0, 1);
    endtask

    // Response monitor: pops the scoreboard on every accepted response.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            if (req_ready != '0 && (busy || $countones(req_ready) > 1))
                check("req_ready_illegal", 64'(req_ready), 0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("sb_id", 64'(rsp_id), 64'(e.id));
                    check("sb_res", rsp_residues, e.res);
                    check("sb_err", 64'(rsp_err), 64'(e.err));
                end
            end
        end
    end

    // Uncontended transaction with full cycle-by-cycle timing checks.
    task automatic single(input int id, input logic [15:0] d, input logic [63:0] exp_res);
        int g, t;
        step();
        req_data[16*id +: 16] = d;
        req_valid[id] = 1'b1;
        push_exp(id, exp_res, 1'b0);
        wait_grant(g, t);
        check("single_grant", 64'(g), 64'(id));
        step();
        req_valid[id] = 1'b0;
        #1;
        check("start_T1", 64'(enc_start), 1);
        check("data_T1", 64'(enc_data_in), 64'(d));
        step();
        #1;
        check("start_T2", 64'(enc_start), 0);
        check("valid_T2", 64'(rsp_valid), 0);
        step();
        #1;
        check("valid_T3", 64'(rsp_valid), 1);
        check("id_T3", 64'(rsp_id), 64'(id));
        check("err_T3", 64'(rsp_err), 0);
        check("res_T3", rsp_residues, exp_res);
        step();
        #1;
        check("idle_T4", 64'(busy), 0);
    endtask

    initial begin
        int g, t, prev;

        // Reset state, with every requester already asking.
        for (int i = 0; i < N; i++) req_data[16*i +: 16] = 16'(1000 + 111 * i);
        req_valid = 4'hF;
        #2;
        check("rst_req_ready", 64'(req_ready), 0);
        check("rst_enc_start", 64'(enc_start), 0);
        check("rst_enc_data", 64'(enc_data_in), 0);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_rsp_id", 64'(rsp_id), 0);
        check("rst_rsp_res", rsp_residues, 0);
        check("rst_rsp_err", 64'(rsp_err), 0);
        check("rst_busy", 64'(busy), 0);

        // Round robin with all four valid continuously from reset.
        for (int k = 0; k < 5; k++) push_exp(k % N, model_res(16'(1000 + 111 * (k % N))), 1'b0);
        step();
        rst_n = 1'b1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, t);
            check("rr_order", 64'(g), 64'(k % N));
            if (k > 0) check("rr_spacing", 64'(t - prev), 4);
            prev = t;
            step();
            if (k == 4) req_valid = '0;
        end
        repeat (4) step();

        // Directed data values.
        single(0, 16'd1000, pack(229, 232, 24, 56, 10, 46));
        single(1, 16'd0, 64'd0);
        // 65535 = 55*1191 + 30 = 53*1236 + 27
        single(2, 16'd65535, pack(0, 255, 21, 45, 30, 27));

        // Backpressure: response held for five cycles, no grant meanwhile.
        step();
        rsp_ready = 1'b0;
        req_data[16*3 +: 16] = 16'd4321;
        req_valid[3] = 1'b1;
        push_exp(3, model_res(16'd4321), 1'b0);
        wait_grant(g, t);
        check("bp_grant", 64'(g), 3);
        step();
        req_valid[3] = 1'b0;
        req_data[15:0] = 16'd555;
        req_valid[0] = 1'b1;
        push_exp(0, model_res(16'd555), 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            check("bp_valid", 64'(rsp_valid), 1);
            check("bp_id", 64'(rsp_id), 3);
            check("bp_res", rsp_residues, model_res(16'd4321));
            check("bp_ready_low", 64'(req_ready), 0);
        end
        step();
        rsp_ready = 1'b1;
        #1;
        check("bp_no_grant_yet", 64'(req_ready), 0);
        step();
        #1;
        check("bp_next_grant", 64'(req_ready), 64'(4'b0001));
        step();
        req_valid[0] = 1'b0;
        repeat (4) step();

        // Timeout: encoder never answers, then a stray done arrives late.
        stub_en = 1'b0;
        rsp_ready = 1'b0;
        req_data[16*1 +: 16] = 16'd1234;
        req_valid[1] = 1'b1;
        push_exp(1, 64'd0, 1'b1);
        wait_grant(g, t);
        check("to_grant", 64'(g), 1);
        step();
        req_valid[1] = 1'b0;
        repeat (4) step();
        #1;
        check("to_valid_T5", 64'(rsp_valid), 0);
        check("to_busy_T5", 64'(busy), 1);
        step();
        #1;
        check("to_valid_T6", 64'(rsp_valid), 1);
        check("to_err_T6", 64'(rsp_err), 1);
        check("to_res_T6", rsp_residues, 0);
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        step();
        #1;
        check("late_done_res", rsp_residues, 0);
        check("late_done_err", 64'(rsp_err), 1);
        check("late_done_valid", 64'(rsp_valid), 1);
        rsp_ready = 1'b1;
        step();
        stub_en = 1'b1;

        // Reset during WAIT after granting requester 2 (pointer moves to 3).
        stub_en = 1'b0;
        req_data[16*2 +: 16] = 16'd777;
        req_valid[2] = 1'b1;
        wait_grant(g, t);
        check("rw_grant", 64'(g), 2);
        step();
        req_valid[2] = 1'b0;
        step();
        step();
        #1;
        check("rw_busy_before", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rw_busy", 64'(busy), 0);
        check("rw_enc_data", 64'(enc_data_in), 0);
        check("rw_rsp_id", 64'(rsp_id), 0);
        check("rw_rsp_valid", 64'(rsp_valid), 0);
        check("rw_enc_start", 64'(enc_start), 0);
        step();
        rst_n = 1'b1;
        stub_en = 1'b1;
        req_data[16*2 +: 16] = 16'd888;
        req_data[16*3 +: 16] = 16'd999;
        req_valid = 4'b1100;
        push_exp(2, model_res(16'd888), 1'b0);
        push_exp(3, model_res(16'd999), 1'b0);
        wait_grant(g, t);
        check("rw_first_grant", 64'(g), 2);
        step();
        req_valid[2] = 1'b0;
        wait_grant(g, t);
        check("rw_second_grant", 64'(g), 3);
        step();
        req_valid[3] = 1'b0;
        repeat (6) step();

        check("sb_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
